// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory stage of a 5-stage RISC-V pipeline.
//   * Resolves branch / jal / jalr into a redirect request with its target.
//   * Runs word loads/stores over a req/gnt/rvalid data bus. It stalls the
//     upstream stages while an access is in flight.
//   * Aborts an access as a bus error after TIMEOUT_CYCLES cycles in REQ+WAIT.
//   * Holds the M/WB pipeline register that feeds the register-file write port.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   PC_M .. rd_wen_M                EX/M pipeline register contents
//   dmem_req/we/addr/wdata          data-memory request (registered)
//   dmem_gnt/rvalid/rdata           data-memory handshake and load data
//   stall_M, redirect_M,            pipeline control (combinational)
//   PC_target_M
//   misalign_M, bus_err_M           single-cycle fault pulses (combinational)
//   rd_wdata_W/rd_waddr_W/rd_wen_W  writeback port (M/WB register)
// ----------------------------------------------------------------------------
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int XLEN           = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] PC_M,
   input  logic [XLEN-1:0] PC_branch_M,
   input  logic [XLEN-1:0] imm_M,
   input  logic [XLEN-1:0] rs2_rdata_M,
   input  logic [4:0]      rd_waddr_M,
   input  logic            zero_M,
   input  logic [XLEN-1:0] alu_result_M,
   input  logic            branch_M,
   input  logic            MemWrite_M,
   input  logic            jal_M,
   input  logic            jalr_M,
   input  logic [1:0]      PMAItoReg_M,
   input  logic            rd_wen_M,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_M,
   output logic            redirect_M,
   output logic [XLEN-1:0] PC_target_M,
   output logic            misalign_M,
   output logic            bus_err_M,
   output logic [XLEN-1:0] rd_wdata_W,
   output logic [4:0]      rd_waddr_W,
   output logic            rd_wen_W
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } state_t;

   // The counter never exceeds TIMEOUT_CYCLES-1.
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic            req_r;
   logic            we_r;
   logic [XLEN-1:0] addr_r;
   logic [XLEN-1:0] wdata_r;
   logic [XLEN-1:0] wb_wdata_r;
   logic [4:0]      wb_waddr_r;
   logic            wb_wen_r;

   logic            mem_op_s;
   logic            misaligned_s;
   logic            start_s;
   logic            mis_s;
   logic            done_s;
   logic            timeout_s;
   logic            stall_s;
   logic            redirect_s;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] wb_data_s;

   // Access classification and stall generation.
   always_comb begin
      // While reset is asserted, no incoming op may stall or raise a fault pulse.
      mem_op_s     = rst_n & (MemWrite_M | (PMAItoReg_M == 2'b01));
      misaligned_s = (alu_result_M[1:0] != 2'b00);
      start_s      = (state_r == IDLE) & mem_op_s & ~misaligned_s;
      mis_s        = (state_r == IDLE) & mem_op_s & misaligned_s;
      done_s       = (state_r == WAIT) & dmem_rvalid;
      // A timeout only fires when the current cycle does not complete the access.
      timeout_s    = ((state_r == REQ) | (state_r == WAIT)) & (cnt_r == CNT_LAST) & ~done_s;
      case (state_r)
         IDLE:    stall_s = start_s;
         REQ:     stall_s = ~timeout_s;
         WAIT:    stall_s = ~dmem_rvalid & ~timeout_s;
         default: stall_s = 1'b0;
      endcase
   end

   // Branch / jump redirect and its target.
   always_comb begin
      redirect_s = (branch_M & zero_M) | jal_M | jalr_M;
      if (!redirect_s) begin
         target_s = {XLEN{1'b0}};
      end else if (jalr_M) begin
         target_s = {alu_result_M[XLEN-1:1], 1'b0};
      end else begin
         target_s = PC_branch_M;
      end
   end

   // Writeback data select.
   always_comb begin
      case (PMAItoReg_M)
         2'b00:   wb_data_s = alu_result_M;
         2'b01:   wb_data_s = dmem_rdata;
         2'b10:   wb_data_s = PC_M + XLEN'(4);
         2'b11:   wb_data_s = imm_M;
         default: wb_data_s = alu_result_M;
      endcase
   end

   // Bus FSM with timeout counter and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= {XLEN{1'b0}};
         wdata_r <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r <= REQ;
                  cnt_r   <= {CW{1'b0}};
                  req_r   <= 1'b1;
                  we_r    <= MemWrite_M;
                  addr_r  <= alu_result_M;
                  wdata_r <= rs2_rdata_M;
               end
            end
            REQ: begin
               // A gnt coinciding with the timeout is not honoured.
               if (timeout_s || dmem_gnt) begin
                  state_r <= timeout_s ? IDLE : WAIT;
                  req_r   <= 1'b0;
                  we_r    <= 1'b0;
                  addr_r  <= {XLEN{1'b0}};
                  wdata_r <= {XLEN{1'b0}};
               end
               cnt_r <= cnt_r + CNT_ONE;
            end
            WAIT: begin
               if (done_s || timeout_s) begin
                  state_r <= IDLE;
               end
               cnt_r <= cnt_r + CNT_ONE;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CW{1'b0}};
               req_r   <= 1'b0;
               we_r    <= 1'b0;
               addr_r  <= {XLEN{1'b0}};
               wdata_r <= {XLEN{1'b0}};
            end
         endcase
      end
   end

   // M/WB pipeline register; a stall inserts a bubble and keeps data/addr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_wdata_r <= {XLEN{1'b0}};
         wb_waddr_r <= 5'd0;
         wb_wen_r   <= 1'b0;
      end else if (stall_s) begin
         wb_wen_r   <= 1'b0;
      end else begin
         wb_wdata_r <= wb_data_s;
         wb_waddr_r <= rd_waddr_M;
         wb_wen_r   <= rd_wen_M & ~mis_s & ~timeout_s;
      end
   end

   assign dmem_req    = req_r;
   assign dmem_we     = we_r;
   assign dmem_addr   = addr_r;
   assign dmem_wdata  = wdata_r;
   assign stall_M     = stall_s;
   assign redirect_M  = redirect_s;
   assign PC_target_M = target_s;
   assign misalign_M  = mis_s;
   assign bus_err_M   = timeout_s;
   assign rd_wdata_W  = wb_wdata_r;
   assign rd_waddr_W  = wb_waddr_r;
   assign rd_wen_W    = wb_wen_r;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. The reference model plans each access
// as a timeline. The stimulus chooses the gnt delay g and the rvalid delay r.
// An access that fits in TIMEOUT_CYCLES completes at cycle g+r. Otherwise it
// aborts at cycle T. The expected bus, stall and fault outputs follow from
// that plan. A compare process checks every output on each falling edge.
// ----------------------------------------------------------------------------
module tb_mem_stage;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PC_M, PC_branch_M, imm_M, rs2_rdata_M, alu_result_M;
   logic [4:0]  rd_waddr_M;
   logic        zero_M, branch_M, MemWrite_M, jal_M, jalr_M, rd_wen_M;
   logic [1:0]  PMAItoReg_M;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        stall_M, redirect_M, misalign_M, bus_err_M, rd_wen_W;
   logic [31:0] PC_target_M, rd_wdata_W;
   logic [4:0]  rd_waddr_W;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(T), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .PC_M(PC_M), .PC_branch_M(PC_branch_M),
      .imm_M(imm_M), .rs2_rdata_M(rs2_rdata_M), .rd_waddr_M(rd_waddr_M),
      .zero_M(zero_M), .alu_result_M(alu_result_M), .branch_M(branch_M),
      .MemWrite_M(MemWrite_M), .jal_M(jal_M), .jalr_M(jalr_M),
      .PMAItoReg_M(PMAItoReg_M), .rd_wen_M(rd_wen_M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .stall_M(stall_M), .redirect_M(redirect_M),
      .PC_target_M(PC_target_M), .misalign_M(misalign_M), .bus_err_M(bus_err_M),
      .rd_wdata_W(rd_wdata_W), .rd_waddr_W(rd_waddr_W), .rd_wen_W(rd_wen_W)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Expected values for the current cycle plus the modelled writeback port.
   logic        chk_en = 1'b0;
   logic        e_stall, e_req, e_mis, e_err, e_redir;
   logic [31:0] e_target;
   logic [31:0] m_wdata;
   logic [4:0]  m_waddr;
   logic        m_wen;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value that the instruction currently in M would write back.
   function automatic logic [31:0] wb_value();
      case (PMAItoReg_M)
         2'b00:   return alu_result_M;
         2'b01:   return dmem_rdata;
         2'b10:   return PC_M + 32'd4;
         default: return imm_M;
      endcase
   endfunction

   // Compare process: every output against the model, once per cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         e_redir  = (branch_M && zero_M) || jal_M || jalr_M;
         e_target = !e_redir ? 32'h0 : (jalr_M ? (alu_result_M & 32'hFFFF_FFFE) : PC_branch_M);
         chk1 ("stall_M",     stall_M,     e_stall);
         chk1 ("dmem_req",    dmem_req,    e_req);
         chk1 ("dmem_we",     dmem_we,     e_req & MemWrite_M);
         chk32("dmem_addr",   dmem_addr,   e_req ? alu_result_M : 32'h0);
         chk32("dmem_wdata",  dmem_wdata,  e_req ? rs2_rdata_M : 32'h0);
         chk1 ("misalign_M",  misalign_M,  e_mis);
         chk1 ("bus_err_M",   bus_err_M,   e_err);
         chk1 ("redirect_M",  redirect_M,  e_redir);
         chk32("PC_target_M", PC_target_M, e_target);
         chk32("rd_wdata_W",  rd_wdata_W,  m_wdata);
         chk32("rd_waddr_W",  {27'd0, rd_waddr_W}, {27'd0, m_waddr});
         chk1 ("rd_wen_W",    rd_wen_W,    m_wen);
      end
   end

   // One clock cycle with the inputs as currently driven; updates the WB model.
   task automatic tick(input logic stall_e, input logic mis_e, input logic err_e, input logic req_e);
      e_stall = stall_e; e_mis = mis_e; e_err = err_e; e_req = req_e;
      @(posedge clk);
      if (stall_e) begin
         m_wen = 1'b0;
      end else begin
         m_wdata = wb_value();
         m_waddr = rd_waddr_M;
         m_wen   = rd_wen_M && !mis_e && !err_e;
      end
      #1;
   endtask

   task automatic set_common();
      PC_M        = $urandom;
      PC_branch_M = $urandom;
      imm_M       = $urandom;
      rs2_rdata_M = $urandom;
      rd_waddr_M  = 5'($urandom_range(0, 31));
      branch_M    = 1'($urandom_range(0, 1));
      zero_M      = 1'($urandom_range(0, 1));
      jal_M       = ($urandom_range(0, 5) == 0);
      jalr_M      = ($urandom_range(0, 5) == 0);
      dmem_gnt    = 1'b0;
      dmem_rdata  = $urandom;
   endtask

   task automatic do_alu();
      int v;
      set_common();
      v            = $urandom_range(0, 2);
      PMAItoReg_M  = (v == 0) ? 2'b00 : ((v == 1) ? 2'b10 : 2'b11);
      MemWrite_M   = 1'b0;
      alu_result_M = $urandom;
      rd_wen_M     = 1'($urandom_range(0, 1));
      dmem_rvalid  = 1'($urandom_range(0, 1));
      tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_mis();
      logic [31:0] a;
      set_common();
      a            = $urandom;
      a[1:0]       = 2'($urandom_range(1, 3));
      alu_result_M = a;
      MemWrite_M   = 1'($urandom_range(0, 1));
      PMAItoReg_M  = MemWrite_M ? 2'b00 : 2'b01;
      rd_wen_M     = !MemWrite_M;
      dmem_rvalid  = 1'($urandom_range(0, 1));
      tick(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Aligned access: gnt on REQ cycle g, rvalid on WAIT cycle r.
   task automatic do_mem(input logic store, input logic [31:0] addr, input logic [31:0] data,
                         input int g, input int r, input logic [31:0] rdat);
      logic ok;
      int   last;
      set_common();
      jal_M        = 1'b0;
      jalr_M       = 1'b0;
      MemWrite_M   = store;
      PMAItoReg_M  = store ? 2'b00 : 2'b01;
      rd_wen_M     = !store;
      alu_result_M = addr;
      rs2_rdata_M  = data;
      ok   = (g + r <= T);
      last = ok ? g + r : T;
      for (int k = 0; k <= last; k++) begin
         dmem_gnt = (k == g);
         if (ok && k == last) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdat;
         end else if (k <= g) begin
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
         end else begin
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
         end
         tick(k < last, 1'b0, !ok && k == last, k >= 1 && k <= g);
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int kind;
      logic [31:0] a;
      rst_n = 1'b0;
      PC_M = 32'h0; PC_branch_M = 32'h0; imm_M = 32'h0; rs2_rdata_M = 32'h0;
      alu_result_M = 32'h0; rd_waddr_M = 5'd0; zero_M = 1'b0; branch_M = 1'b0;
      MemWrite_M = 1'b0; jal_M = 1'b0; jalr_M = 1'b0; PMAItoReg_M = 2'b00;
      rd_wen_M = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      m_wdata = 32'h0; m_waddr = 5'd0; m_wen = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1 ("reset_req",   dmem_req,   1'b0);
      chk1 ("reset_stall", stall_M,    1'b0);
      chk32("reset_wdata", rd_wdata_W, 32'h0);
      chk1 ("reset_wen",   rd_wen_W,   1'b0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // ALU op writeback.
      set_common();
      branch_M = 1'b0; jal_M = 1'b0; jalr_M = 1'b0; MemWrite_M = 1'b0;
      PMAItoReg_M = 2'b00; alu_result_M = 32'h1234; rd_waddr_M = 5'd5; rd_wen_M = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk32("lit_alu_wdata", rd_wdata_W, 32'h1234);
      chk32("lit_alu_waddr", {27'd0, rd_waddr_W}, 32'd5);
      chk1 ("lit_alu_wen",   rd_wen_W,   1'b1);

      // Branch taken / not taken, jalr, jal.
      branch_M = 1'b1; zero_M = 1'b1; PC_branch_M = 32'h400;
      #1;
      chk1 ("lit_br_redir",  redirect_M,  1'b1);
      chk32("lit_br_target", PC_target_M, 32'h400);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      zero_M = 1'b0;
      #1;
      chk1 ("lit_nbr_redir", redirect_M, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      branch_M = 1'b0; jalr_M = 1'b1; alu_result_M = 32'h803;
      #1;
      chk32("lit_jalr_target", PC_target_M, 32'h802);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      jalr_M = 1'b0; jal_M = 1'b1; PC_M = 32'h40; PMAItoReg_M = 2'b10; rd_wen_M = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk32("lit_jal_link", rd_wdata_W, 32'h44);

      // Load with gnt after 2 REQ cycles and rvalid 3 cycles later.
      do_mem(1'b0, 32'h100, 32'h0, 2, 3, 32'hDEADBEEF);
      chk32("lit_load_data", rd_wdata_W, 32'hDEADBEEF);
      chk1 ("lit_load_wen",  rd_wen_W,   1'b1);

      // Store.
      do_mem(1'b1, 32'h200, 32'hA5A5A5A5, 1, 1, 32'h0);
      chk1("lit_store_wen", rd_wen_W, 1'b0);

      // Misaligned load.
      set_common();
      jal_M = 1'b0; jalr_M = 1'b0; MemWrite_M = 1'b0; PMAItoReg_M = 2'b01;
      alu_result_M = 32'h102; rd_wen_M = 1'b1; dmem_rvalid = 1'b0;
      #1;
      chk1("lit_mis_pulse", misalign_M, 1'b1);
      chk1("lit_mis_stall", stall_M,    1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      chk1("lit_mis_req", dmem_req, 1'b0);
      chk1("lit_mis_wen", rd_wen_W, 1'b0);

      // Timeout: gnt never arrives.
      do_mem(1'b0, 32'h300, 32'h0, T + 3, 1, 32'h0);
      chk1("lit_to_wen", rd_wen_W, 1'b0);
      chk1("lit_to_req", dmem_req, 1'b0);

      // Randomised mix.
      for (int i = 0; i < 400; i++) begin
         kind = $urandom_range(0, 99);
         if (kind < 40) begin
            do_alu();
         end else if (kind < 52) begin
            do_mis();
         end else begin
            a      = $urandom;
            a[1:0] = 2'b00;
            do_mem(1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(1, T + 1), $urandom_range(1, T), $urandom);
         end
      end

      // Reset in the middle of WAIT, followed by a late rvalid.
      set_common();
      jal_M = 1'b0; jalr_M = 1'b0; MemWrite_M = 1'b0; PMAItoReg_M = 2'b01;
      alu_result_M = 32'h500; rd_wen_M = 1'b1; dmem_rvalid = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      dmem_gnt = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      dmem_gnt = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk1 ("rst_mid_req",   dmem_req,   1'b0);
      chk1 ("rst_mid_stall", stall_M,    1'b0);
      chk32("rst_mid_wdata", rd_wdata_W, 32'h0);
      chk32("rst_mid_waddr", {27'd0, rd_waddr_W}, 32'h0);
      chk1 ("rst_mid_wen",   rd_wen_W,   1'b0);
      m_wdata = 32'h0; m_waddr = 5'd0; m_wen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      MemWrite_M = 1'b0; PMAItoReg_M = 2'b00; rd_wen_M = 1'b0;
      branch_M = 1'b0; jal_M = 1'b0; jalr_M = 1'b0;
      chk_en = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hCAFEF00D;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      dmem_rvalid = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk1("rst_late_rvalid_wen", rd_wen_W, 1'b0);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
